// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Optional match counter is enabled by defining SEQ_DET_COUNT_EN.
package seq_det_pkg;

    localparam int LEN_MIN   = 2;
    localparam int LEN_MAX   = 32;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 32;

    typedef enum logic [1:0] {
        CTL_IDLE,
        CTL_LOAD,
        CTL_SAMPLE
    } ctl_e;

    function automatic int fill_w(input int len);
        return $clog2(len + 1);
    endfunction

    // All-ones value for a counter of the given width.
    function automatic logic [CNT_W_MAX-1:0] cnt_sat(input int w);
        logic [63:0] one_hot;
        one_hot = 64'd1 << w;
        return CNT_W_MAX'(one_hot - 64'd1);
    endfunction

endpackage

// File: rtl/seq_history.sv
// Serial history shift register with saturating valid-bit fill count.
// hist_n/fill_n are the post-sample values the top compares against.
module seq_history
    import seq_det_pkg::*;
#(
    parameter int LEN = 4,
    parameter int FW  = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    input  logic           in,
    input  logic           clear,
    input  logic           drop,
    output logic [LEN-1:0] hist_n,
    output logic [FW-1:0]  fill_n
);

    localparam logic [FW-1:0] FILL_FULL = FW'(LEN);

    logic [LEN-1:0] hist;
    logic [FW-1:0]  fill;

    always_comb begin
        hist_n = hist;
        fill_n = fill;
        if (in_valid) begin
            hist_n = {hist[LEN-2:0], in};
            fill_n = (fill == FILL_FULL) ? fill : fill + 1'b1;
        end
    end

    // drop restarts the fill so the next match needs LEN fresh bits
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            hist <= '0;
            fill <= '0;
        end else if (in_valid) begin
            hist <= hist_n;
            fill <= drop ? '0 : fill_n;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable LEN-bit serial pattern detector with overlap control.
// Define SEQ_DET_COUNT_EN to add the saturating match counter port.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int             LEN             = 4,
    parameter logic [LEN-1:0] DEFAULT_PATTERN = 4'b1010,
    parameter int             CNT_W           = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    input  logic             load,
    input  logic [LEN-1:0]   pattern_in,
    output logic             y
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);

    localparam int FW = fill_w(LEN);
    localparam logic [FW-1:0] FILL_FULL = FW'(LEN);

    ctl_e           ctl;
    logic [LEN-1:0] pattern;
    logic [LEN-1:0] hist_n;
    logic [FW-1:0]  fill_n;
    logic           match;
    logic           drop;

    // load has priority over a concurrent sample
    always_comb begin
        ctl = CTL_IDLE;
        priority case (1'b1)
            load:     ctl = CTL_LOAD;
            in_valid: ctl = CTL_SAMPLE;
            default:  ctl = CTL_IDLE;
        endcase
    end

    assign match = (ctl == CTL_SAMPLE)
                 && (fill_n == FILL_FULL)
                 && (hist_n == pattern);
    assign drop  = match && !overlap;

    seq_history #(
        .LEN (LEN),
        .FW  (FW)
    ) u_hist (
        .clock    (clock),
        .reset    (reset),
        .in_valid (ctl == CTL_SAMPLE),
        .in       (in),
        .clear    (ctl == CTL_LOAD),
        .drop     (drop),
        .hist_n   (hist_n),
        .fill_n   (fill_n)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pattern <= DEFAULT_PATTERN;
            y       <= 1'b0;
        end else begin
            y <= match;
            if (ctl == CTL_LOAD) begin
                pattern <= pattern_in;
            end
        end
    end

`ifdef SEQ_DET_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_sat(CNT_W));

    always_ff @(posedge clock) begin
        if (reset || load) begin
            count <= '0;
        end else if (match && count != CNT_SAT) begin
            count <= count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: directed streams then random traffic vs. a queue model.
// Also checks count when built with SEQ_DET_COUNT_EN.
module tb_seq_detector_param;

    localparam int             LEN   = 4;
    localparam logic [LEN-1:0] DEF   = 4'b1010;
    localparam int             CNT_W = 2;
    localparam int             SAT   = (1 << CNT_W) - 1;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in = 1'b0;
    logic           overlap = 1'b1;
    logic           load = 1'b0;
    logic [LEN-1:0] pattern_in = '0;
    logic           y;
`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] count;
`endif

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [LEN-1:0] m_pat;
    bit             mq[$];
    logic           m_y;
    int             m_cnt;

    always #5 clock = ~clock;

    seq_detector_param #(
        .LEN             (LEN),
        .DEFAULT_PATTERN (DEF),
        .CNT_W           (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in         (in),
        .overlap    (overlap),
        .load       (load),
        .pattern_in (pattern_in),
        .y          (y)
`ifdef SEQ_DET_COUNT_EN
        ,
        .count      (count)
`endif
    );

    task automatic step(input logic r, input logic v, input logic b,
                        input logic ov, input logic ld,
                        input logic [LEN-1:0] p);
        bit hit;
        reset      = r;
        in_valid   = v;
        in         = b;
        overlap    = ov;
        load       = ld;
        pattern_in = p;
        @(posedge clock);
        if (r) begin
            m_pat = DEF;
            mq.delete();
            m_y   = 1'b0;
            m_cnt = 0;
        end else if (ld) begin
            m_pat = p;
            mq.delete();
            m_y   = 1'b0;
            m_cnt = 0;
        end else if (v) begin
            mq.push_back(b);
            if (mq.size() > LEN) void'(mq.pop_front());
            hit = (mq.size() == LEN);
            if (hit) begin
                for (int i = 0; i < LEN; i++) begin
                    if (mq[i] != m_pat[LEN-1-i]) hit = 1'b0;
                end
            end
            m_y = hit;
            if (hit) begin
                if (m_cnt < SAT) m_cnt++;
                if (!ov) mq.delete();
            end
        end else begin
            m_y = 1'b0;
        end
        #1;
        checks++;
        assert (y === m_y) else begin
            errors++;
            $error("FAIL y: observed %0b expected %0b", y, m_y);
        end
`ifdef SEQ_DET_COUNT_EN
        checks++;
        assert (count === CNT_W'(m_cnt)) else begin
            errors++;
            $error("FAIL count: observed %0d expected %0d", count, m_cnt);
        end
`endif
        if (y === 1'b1) pulses++;
    endtask

    task automatic vbit(input logic b, input logic ov);
        step(1'b0, 1'b1, b, ov, 1'b0, '0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
        pulses = 0;
    endtask

    task automatic check_pulses(input string tag, input int exp);
        checks++;
        assert (pulses === exp) else begin
            errors++;
            $error("FAIL %s pulses: observed %0d expected %0d", tag, pulses, exp);
        end
        pulses = 0;
    endtask

    initial begin
        m_pat = DEF;
        m_y   = 1'b0;
        m_cnt = 0;

        // reset beats a concurrent load of 1111
        do_reset();
        do_reset();

        // overlapping 1010
        for (int i = 0; i < 6; i++) vbit(1'(i % 2 == 0), 1'b1);
        check_pulses("overlap", 2);

        do_reset();
        for (int i = 0; i < 8; i++) vbit(1'(i % 2 == 0), 1'b0);
        check_pulses("non_overlap", 2);

        // gaps hold partial match
        do_reset();
        vbit(1'b1, 1'b1);
        vbit(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'(i % 2), 1'b1, 1'b0, '0);
        vbit(1'b1, 1'b1);
        vbit(1'b0, 1'b1);
        check_pulses("gap", 1);

        // load mid-stream, concurrent bit dropped
        do_reset();
        vbit(1'b1, 1'b1);
        vbit(1'b0, 1'b1);
        vbit(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0110);
        vbit(1'b0, 1'b1);
        vbit(1'b1, 1'b1);
        vbit(1'b1, 1'b1);
        vbit(1'b0, 1'b1);
        check_pulses("load", 1);

        // reset mid-stream restores 1010
        vbit(1'b1, 1'b1);
        vbit(1'b0, 1'b1);
        vbit(1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        vbit(1'b0, 1'b1);
        check_pulses("mid_reset", 0);
        for (int i = 0; i < 4; i++) vbit(1'(i % 2 == 0), 1'b1);
        check_pulses("default_back", 1);

        // counter saturation run
        do_reset();
        for (int i = 0; i < 12; i++) vbit(1'(i % 2 == 0), 1'b1);
        check_pulses("sat_run", 5);

        // all-ones pattern, constant stream
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
        for (int i = 0; i < 8; i++) vbit(1'b1, 1'b1);
        check_pulses("all_ones", 5);

        // random traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic r, ld, v, b, ov;
            logic [LEN-1:0] p;
            r  = ($urandom_range(0, 149) == 0);
            ld = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom);
            ov = ($urandom_range(0, 9) != 0) ? overlap : ~overlap;
            p  = LEN'($urandom);
            step(r, v, b, ov, ld, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
